// File: rtl/servo_waypoint_sequencer_pkg.sv
// Shared types, duty limits and helpers for the servo waypoint sequencer.
package servo_pkg;

    localparam int DUTY_W    = 6;
    localparam int DC_MIN    = 10;
    localparam int DC_MAX    = 54;
    localparam int DC_CENTER = 32;

    typedef logic [DUTY_W-1:0] duty_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SLEW  = 3'd3,
        DWELL = 3'd4,
        NEXT  = 3'd5
    } state_t;

    // Limit a duty value to the mechanical range of the servos.
    function automatic duty_t clamp(input duty_t v);
        if (v < duty_t'(DC_MIN)) begin
            return duty_t'(DC_MIN);
        end
        if (v > duty_t'(DC_MAX)) begin
            return duty_t'(DC_MAX);
        end
        return v;
    endfunction

    // Move one LSB toward the target, or hold when already there.
    function automatic duty_t step_toward(input duty_t cur, input duty_t tgt);
        if (cur < tgt) begin
            return cur + duty_t'(1);
        end
        if (cur > tgt) begin
            return cur - duty_t'(1);
        end
        return cur;
    endfunction

endpackage

// File: rtl/servo_waypoint_sequencer_if.sv
// Read port of the waypoint position memory (synchronous, one-cycle latency).
interface servo_waypoint_sequencer_if #(
    parameter int ADDR_W = 2
);
    import servo_pkg::*;

    logic [ADDR_W-1:0] Rd_Addr;
    duty_t             Rd_X;
    duty_t             Rd_Y;

    // The sequencer addresses the memory and consumes the stored positions.
    modport master (output Rd_Addr, input Rd_X, input Rd_Y);
    // The position memory answers one cycle after the address.
    modport slave  (input Rd_Addr, output Rd_X, output Rd_Y);

endinterface

// File: rtl/servo_waypoint_sequencer_ms_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV sysclk cycles.
module ms_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic sysclk,
    input  logic Reset_Sw,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(TICK_DIV - 1));

    // Count 0..TICK_DIV-1 and wrap; never restarted by the sequencer state.
    always_ff @(posedge sysclk) begin
        // NOTE: registered state is always updated with <= so every flop samples pre-edge values.
        if (!Reset_Sw) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/servo_waypoint_sequencer.sv
// Waypoint tour player: owns DC_X/DC_Y, passing manual duties through when idle
// and slewing toward stored pan/tilt positions during playback.
module servo_waypoint_sequencer
    import servo_pkg::*;
#(
    parameter int ADDR_W      = 2,
    parameter int TICK_DIV    = 50000,
    parameter int DWELL_TICKS = 500
) (
    input  logic                       sysclk,
    input  logic                       Reset_Sw,
    input  logic                       Play_Sw,
    input  logic                       Bt_Next,
    input  duty_t                      Duty_X,
    input  duty_t                      Duty_Y,
    input  logic [ADDR_W:0]            Slot_Count,
    servo_waypoint_sequencer_if.master mem,
    output duty_t                      DC_X,
    output duty_t                      DC_Y,
    output logic                       Playing,
    output logic [ADDR_W-1:0]          Slot
);

    localparam int DW_W = $clog2(DWELL_TICKS + 1);

    state_t            state;
    duty_t             tgt_x;
    duty_t             tgt_y;
    logic [DW_W-1:0]   dwell_cnt;
    logic              tick;
    logic              abort;
    logic              at_target;
    logic [ADDR_W:0]   slot_plus1;
    logic              slot_last;

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .sysclk   (sysclk),
        .Reset_Sw (Reset_Sw),
        .tick     (tick)
    );

    // Memory always reads the current waypoint; Slot is itself a register.
    assign mem.Rd_Addr = Slot;

    // An empty tour is treated exactly like the play switch being off.
    assign abort     = !Play_Sw || (Slot_Count == '0);
    assign at_target = (DC_X == tgt_x) && (DC_Y == tgt_y);

    // Wrap when this is the last valid slot, or when Slot_Count shrank below Slot.
    assign slot_plus1 = {1'b0, Slot} + {{ADDR_W{1'b0}}, 1'b1};
    assign slot_last  = (slot_plus1 >= Slot_Count);

    // Tour FSM with registered duty, slot, target and dwell outputs.
    always_ff @(posedge sysclk) begin
        if (!Reset_Sw) begin
            // NOTE: targets and dwell count are cleared too, so no stale waypoint survives a reset.
            state     <= IDLE;
            DC_X      <= duty_t'(DC_CENTER);
            DC_Y      <= duty_t'(DC_CENTER);
            tgt_x     <= '0;
            tgt_y     <= '0;
            dwell_cnt <= '0;
            Slot      <= '0;
            Playing   <= 1'b0;
        end else if (state == IDLE) begin
            DC_X <= clamp(Duty_X);
            DC_Y <= clamp(Duty_Y);
            if (!abort) begin
                state   <= FETCH;
                Playing <= 1'b1;
            end
        end else if (abort) begin
            // Duty holds here; manual passthrough starts from the IDLE cycle.
            state   <= IDLE;
            Playing <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    tgt_x <= clamp(mem.Rd_X);
                    tgt_y <= clamp(mem.Rd_Y);
                    state <= SLEW;
                end
                SLEW: begin
                    if (Bt_Next) begin
                        state <= NEXT;
                    end else if (at_target) begin
                        dwell_cnt <= '0;
                        state     <= DWELL;
                    end else if (tick) begin
                        DC_X <= step_toward(DC_X, tgt_x);
                        DC_Y <= step_toward(DC_Y, tgt_y);
                    end
                end
                DWELL: begin
                    if (Bt_Next) begin
                        state <= NEXT;
                    end else if (tick) begin
                        if (dwell_cnt == DW_W'(DWELL_TICKS - 1)) begin
                            state <= NEXT;
                        end else begin
                            dwell_cnt <= dwell_cnt + DW_W'(1);
                        end
                    end
                end
                NEXT: begin
                    Slot  <= slot_last ? '0 : slot_plus1[ADDR_W-1:0];
                    state <= FETCH;
                end
                default: begin
                    state   <= IDLE;
                    Playing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servo_waypoint_sequencer.sv
// Self-checking bench: directed tour scenarios plus randomized stimulus, with a
// cycle-level behavioural model feeding a scoreboard queue and a separate monitor.
module tb_servo_waypoint_sequencer;

    localparam int TICK_DIV    = 4;
    localparam int DWELL_TICKS = 3;
    localparam int ADDR_W      = 2;

    logic       clk = 1'b0;
    logic       reset_sw;
    logic       play_sw;
    logic       bt_next;
    logic [5:0] duty_x;
    logic [5:0] duty_y;
    logic [2:0] slot_count;
    logic [5:0] dc_x;
    logic [5:0] dc_y;
    logic       playing;
    logic [1:0] slot;

    logic [5:0] mem_x [4];
    logic [5:0] mem_y [4];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int dcx;
        int dcy;
        int slot;
        int playing;
        int rd_addr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #10 clk = ~clk;

    servo_waypoint_sequencer_if #(.ADDR_W(ADDR_W)) mem_bus ();

    servo_waypoint_sequencer #(
        .ADDR_W      (ADDR_W),
        .TICK_DIV    (TICK_DIV),
        .DWELL_TICKS (DWELL_TICKS)
    ) dut (
        .sysclk     (clk),
        .Reset_Sw   (reset_sw),
        .Play_Sw    (play_sw),
        .Bt_Next    (bt_next),
        .Duty_X     (duty_x),
        .Duty_Y     (duty_y),
        .Slot_Count (slot_count),
        .mem        (mem_bus),
        .DC_X       (dc_x),
        .DC_Y       (dc_y),
        .Playing    (playing),
        .Slot       (slot)
    );

    // Synchronous position memory with one-cycle read latency.
    always @(posedge clk) begin
        mem_bus.Rd_X <= mem_x[mem_bus.Rd_Addr];
        mem_bus.Rd_Y <= mem_y[mem_bus.Rd_Addr];
    end

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int m_pre, m_dcx, m_dcy, m_tx, m_ty, m_slot, m_setup, m_dwell;
    bit m_play, m_dwelling, m_advance;

    function automatic int clampi(input int v);
        return (v < 10) ? 10 : ((v > 54) ? 54 : v);
    endfunction

    function automatic int toward(input int cur, input int tgt);
        return (tgt > cur) ? cur + 1 : ((tgt < cur) ? cur - 1 : cur);
    endfunction

    // Predict the state after one sysclk edge from the inputs applied to it.
    function automatic void model_edge();
        bit tick;
        if (!reset_sw) begin
            m_dcx = 32; m_dcy = 32; m_slot = 0; m_play = 0; m_pre = 0;
            m_setup = 0; m_dwelling = 0; m_advance = 0; m_dwell = 0;
            m_tx = 0; m_ty = 0;
            return;
        end
        tick  = (m_pre == TICK_DIV - 1);
        m_pre = (m_pre + 1) % TICK_DIV;
        if (!m_play) begin
            m_dcx = clampi(int'(duty_x));
            m_dcy = clampi(int'(duty_y));
            if (play_sw && slot_count != 0) begin
                m_play = 1; m_setup = 2; m_dwelling = 0; m_advance = 0;
            end
        end else if (!play_sw || slot_count == 0) begin
            m_play = 0;
        end else if (m_setup > 0) begin
            // Two cycles of address/read; targets taken on the second.
            if (m_setup == 1) begin
                m_tx = clampi(int'(mem_x[m_slot]));
                m_ty = clampi(int'(mem_y[m_slot]));
            end
            m_setup--;
        end else if (m_advance) begin
            m_slot    = (m_slot + 1 >= int'(slot_count)) ? 0 : m_slot + 1;
            m_advance = 0; m_setup = 2; m_dwelling = 0;
        end else if (bt_next) begin
            m_advance = 1;
        end else if (!m_dwelling) begin
            if (m_dcx == m_tx && m_dcy == m_ty) begin
                m_dwelling = 1; m_dwell = 0;
            end else if (tick) begin
                m_dcx = toward(m_dcx, m_tx);
                m_dcy = toward(m_dcy, m_ty);
            end
        end else if (tick) begin
            m_dwell++;
            if (m_dwell == DWELL_TICKS) m_advance = 1;
        end
    endfunction

    // Apply the current inputs for one edge, queue the expectation, move to the next negedge.
    task automatic step();
        model_edge();
        exp_q.push_back('{m_dcx, m_dcy, m_slot, int'(m_play), m_slot});
        @(negedge clk);
    endtask

    // Monitor: compare every cycle's outputs against the oldest queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("dc_x", int'(dc_x), mon_e.dcx);
                check("dc_y", int'(dc_y), mon_e.dcy);
                check("slot", int'(slot), mon_e.slot);
                check("playing", int'(playing), mon_e.playing);
                check("rd_addr", int'(mem_bus.Rd_Addr), mon_e.rd_addr);
            end
        end
    end

    task automatic wait_dc(input string name, input int x, input int y, input int budget);
        int n = 0;
        while (!(int'(dc_x) == x && int'(dc_y) == y) && n < budget) begin
            step();
            n++;
        end
        check(name, int'(int'(dc_x) == x && int'(dc_y) == y), 1);
    endtask

    task automatic wait_slot(input string name, input int s, input int budget);
        int n = 0;
        while (int'(slot) != s && n < budget) begin
            step();
            n++;
        end
        check(name, int'(slot), s);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_sw = 1'b0; play_sw = 1'b0; bt_next = 1'b0;
        duty_x = 6'd40; duty_y = 6'd32; slot_count = 3'd0;
        for (int i = 0; i < 4; i++) begin
            mem_x[i] = 6'd32;
            mem_y[i] = 6'd32;
        end

        // 1. Reset holds centre duty regardless of manual input.
        step(); step();
        check("rst_dc_x", int'(dc_x), 32);
        check("rst_dc_y", int'(dc_y), 32);
        check("rst_playing", int'(playing), 0);
        check("rst_slot", int'(slot), 0);
        reset_sw = 1'b1;
        step();
        check("release_dc_x", int'(dc_x), 40);

        // 2. Manual values are clamped.
        duty_x = 6'd60; duty_y = 6'd3;
        step();
        check("clamp_hi", int'(dc_x), 54);
        check("clamp_lo", int'(dc_y), 10);

        // 3. Two-slot tour with wrap.
        mem_x[0] = 6'd34; mem_y[0] = 6'd30;
        mem_x[1] = 6'd20; mem_y[1] = 6'd62;
        duty_x = 6'd32; duty_y = 6'd32;
        step(); step();
        slot_count = 3'd2; play_sw = 1'b1;
        step();
        check("play_latency", int'(playing), 1);
        wait_dc("tour_first_step", 33, 31, 20);
        wait_dc("tour_slot0", 34, 30, 20);
        wait_slot("tour_to_slot1", 1, 40);
        wait_dc("tour_slot1", 20, 54, 200);
        wait_slot("tour_wrap", 0, 40);
        check("tour_still_playing", int'(playing), 1);

        // 4. Skip mid-slew holds duty and advances.
        reset_sw = 1'b0; step(); reset_sw = 1'b1;
        wait_dc("skip_at_33", 33, 31, 40);
        bt_next = 1'b1;
        step();
        bt_next = 1'b0;
        check("skip_hold", int'(dc_x), 33);
        step();
        check("skip_slot", int'(slot), 1);
        check("skip_hold2", int'(dc_x), 33);

        // 5. Empty tour behaves as manual.
        play_sw = 1'b0; step(); step();
        slot_count = 3'd0; play_sw = 1'b1; duty_x = 6'd45; duty_y = 6'd12;
        step(); step(); step();
        check("empty_playing", int'(playing), 0);
        check("empty_dc_x", int'(dc_x), 45);
        check("empty_dc_y", int'(dc_y), 12);

        // 6. Abort during dwell, then reset mid-slew.
        slot_count = 3'd2;
        wait_dc("abort_reach", 20, 54, 300);
        step();
        play_sw = 1'b0; duty_x = 6'd50; duty_y = 6'd40;
        step();
        check("abort_playing", int'(playing), 0);
        check("abort_slot", int'(slot), 1);
        check("abort_hold", int'(dc_x), 20);
        step();
        check("abort_manual", int'(dc_x), 50);
        play_sw = 1'b1;
        for (int i = 0; i < 10; i++) step();
        reset_sw = 1'b0;
        step();
        check("rst_slew_dc_x", int'(dc_x), 32);
        check("rst_slew_dc_y", int'(dc_y), 32);
        check("rst_slew_playing", int'(playing), 0);
        reset_sw = 1'b1;

        // 7. Randomized stimulus against the model.
        for (int c = 0; c < 4000; c++) begin
            reset_sw = ($urandom_range(0, 699) != 0);
            bt_next  = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 99) == 0) play_sw = ~play_sw;
            if ($urandom_range(0, 149) == 0) slot_count = 3'($urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0) begin
                duty_x = 6'($urandom_range(0, 63));
                duty_y = 6'($urandom_range(0, 63));
            end
            if (!play_sw && !m_play && $urandom_range(0, 3) == 0) begin
                mem_x[$urandom_range(0, 3)] = 6'($urandom_range(0, 63));
                mem_y[$urandom_range(0, 3)] = 6'($urandom_range(0, 63));
            end
            step();
        end
        bt_next = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/servo_waypoint_sequencer.md
Name: servo_waypoint_sequencer

Overview:
- Plays back the pan/tilt positions held in the position memory as a timed tour, and drives the servo PWM duty registers DC_X/DC_Y.
- When playback is off, passes the manual duty values through, clamped to the servo range.
- During playback it reads each memory slot in turn, slews both axes toward the stored target at one LSB per millisecond, dwells, then advances to the next slot.
- Sits between the position memory and the PWM generators, and is the single owner of DC_X/DC_Y.

Parameters:
- DUTY_W, 6, width of all duty values.
- ADDR_W, 2, memory slot address width (4 slots).
- TICK_DIV, 50000, sysclk cycles per slew/dwell tick (1 ms at 50 MHz).
- DWELL_TICKS, 500, ticks held at each reached waypoint.
- DC_MIN, 10, lowest legal duty.
- DC_MAX, 54, highest legal duty.
- DC_CENTER, 32, reset duty for both axes.

Ports:
- sysclk  in  1  system clock.
- Reset_Sw  in  1  synchronous, active-low reset.
- Play_Sw  in  1  level: 1 = playback, 0 = manual.
- Bt_Next  in  1  single-cycle pulse (already debounced): skip to the next waypoint.
- Duty_X  in  DUTY_W  manual pan duty.
- Duty_Y  in  DUTY_W  manual tilt duty.
- Slot_Count  in  ADDR_W+1  number of valid slots, 0..2^ADDR_W.
- Rd_Addr  out  ADDR_W  memory read address.
- Rd_X  in  DUTY_W  stored pan; valid one cycle after Rd_Addr.
- Rd_Y  in  DUTY_W  stored tilt; same timing as Rd_X.
- DC_X  out  DUTY_W  pan duty to the PWM.
- DC_Y  out  DUTY_W  tilt duty to the PWM.
- Playing  out  1  high in every state except IDLE.
- Slot  out  ADDR_W  current waypoint index.

Behaviour:
- Reset (Reset_Sw=0 at a sysclk edge):
  - DC_X=DC_Y=DC_CENTER; Slot=0; Rd_Addr=0; Playing=0.
  - State=IDLE; prescaler, dwell counter and targets cleared.
  - Reset overrides every other input, in any state.
- Clamp function clamp(v) = max(DC_MIN, min(DC_MAX, v)). It is applied to manual inputs and to memory data; DC_X/DC_Y never leave [DC_MIN, DC_MAX] after reset.
- Prescaler:
  - Free-running 0..TICK_DIV-1.
  - tick=1 for one cycle at the terminal count.
  - Not restarted by state changes.
- Rd_Addr always equals Slot (registered).
- State IDLE:
  - Each cycle DC_X<=clamp(Duty_X), DC_Y<=clamp(Duty_Y).
  - Bt_Next is ignored.
  - If Play_Sw=1 and Slot_Count!=0, go to FETCH with Slot unchanged (a resumed tour starts at the last Slot).
  - If Play_Sw=1 and Slot_Count=0, stay in IDLE.
- State FETCH (1 cycle): Rd_Addr is valid; go to LOAD.
- State LOAD (1 cycle): tgt_X<=clamp(Rd_X), tgt_Y<=clamp(Rd_Y); go to SLEW.
- State SLEW:
  - On each tick, each axis independently moves one step toward its target: DC < tgt gives +1, DC > tgt gives -1, equal holds.
  - When both axes equal their targets (checked every cycle), clear the dwell counter and go to DWELL.
- State DWELL:
  - DC holds.
  - The dwell counter increments on tick; on reaching DWELL_TICKS, go to NEXT.
- State NEXT (1 cycle):
  - Slot<=Slot+1, wrapping to 0 when Slot>=Slot_Count-1. This also covers a Slot_Count that shrank below Slot.
  - Go to FETCH.
- Bt_Next:
  - In SLEW or DWELL, go to NEXT on the next cycle; DC holds its present value with no jump.
  - In FETCH, LOAD or NEXT it is ignored.
- Play_Sw=0:
  - In any non-IDLE state, go to IDLE next cycle; Slot is kept.
  - Manual passthrough resumes on the following cycle.
- Slot_Count=0 while playing: treated as Play_Sw=0.
- Priority: Reset > Play_Sw/Slot_Count abort > Bt_Next > normal transition.
- Latency:
  - Play_Sw rise to FETCH is 1 cycle.
  - First DC step occurs on the first tick after LOAD.

Decomposition:
- Shared package (servo_pkg):
  - State encoding (IDLE, FETCH, LOAD, SLEW, DWELL, NEXT, 3 bits).
  - DUTY_W, DC_MIN, DC_MAX, DC_CENTER.
  - The clamp function.
- One sub-module: ms_tick_gen (parameter TICK_DIV, ports sysclk, Reset_Sw, tick).
- The FSM, slew and dwell logic stay in servo_waypoint_sequencer.

Test Plan:
Bench parameters: TICK_DIV=4, DWELL_TICKS=3, 20 ns clock.
1. Reset: Reset_Sw=0 for 2 cycles with Duty_X=40 -> DC_X=DC_Y=32, Playing=0, Slot=0. On release, DC_X=40 one cycle later.
2. Clamp: Duty_X=60, Duty_Y=3 in IDLE -> DC_X=54, DC_Y=10.
3. Tour:
   - Setup: Slot_Count=2, slot0=(34,30), slot1=(20,62), DC=32/32, Play_Sw=1.
   - Slot 0: Rd_Addr=0; on successive ticks DC_X goes 33, 34 and DC_Y goes 31, 30; then 3 ticks of dwell.
   - Slot 1: Slot=1; DC_X steps down to 20 and DC_Y steps up to 54 (clamped from 62).
   - After dwell, Slot wraps to 0.
4. Bt_Next pulse mid-slew at DC_X=33 -> DC_X stays 33, NEXT then FETCH of slot 1 within 2 cycles.
5. Slot_Count=0 with Play_Sw=1 -> stays IDLE, Playing=0, DC follows manual.
6. Abort and reset:
   - Play_Sw=0 during DWELL -> IDLE next cycle, Slot retained, DC=clamp(Duty) the cycle after.
   - Reset_Sw=0 mid-SLEW -> DC=32, state IDLE.
